// File: rtl/cv32e41s_pkg.sv
// Shared types and helpers for the sequential divider in the EX stage.
package cv32e41s_pkg;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_opcode_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_DIVIDE,
        DIV_FINISH
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

    function automatic logic div_is_signed(input div_opcode_e op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

    function automatic logic div_is_quot(input div_opcode_e op);
        return (op == DIV_DIV) || (op == DIV_DIVU);
    endfunction

    function automatic logic [31:0] div_abs(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? -x : x;
    endfunction

    function automatic logic [31:0] div_bitrev(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/cv32e41s_div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; borrows the ALU CLZ and
// shifter at accept time to skip leading zero quotient bits.
module cv32e41s_div_seq
    import cv32e41s_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kill_i,
    input  logic [1:0]  div_operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        alu_clz_en_o,
    output logic [31:0] alu_clz_data_rev_o,
    input  logic [5:0]  alu_clz_result_i,
    output logic        alu_shift_en_o,
    output logic [5:0]  alu_shift_amt_o,
    output logic [31:0] div_op_b_abs_o,
    input  logic [31:0] alu_op_b_shifted_i
);

    div_state_e  r_state;
    div_opcode_e r_op;
    logic        r_sign_a;
    logic        r_sign_q;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [31:0] r_quot;
    logic [31:0] r_result;
    logic [4:0]  r_cnt;

    div_opcode_e w_op;
    logic        w_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic        w_accept;
    logic        w_div_zero;
    logic        w_ovf;
    logic [31:0] w_special_res;
    logic [32:0] w_diff;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quot_nxt;
    logic [31:0] w_final;
    logic        w_unused_clz_msb;

    assign w_op     = div_opcode_e'(div_operator_i);
    assign w_signed = div_is_signed(w_op);
    assign w_a_abs  = div_abs(op_a_i, w_signed);
    assign w_b_abs  = div_abs(op_b_i, w_signed);

    assign ready_o  = (r_state == DIV_IDLE);
    assign valid_o  = (r_state == DIV_FINISH);
    assign result_o = r_result;
    assign w_accept = valid_i && ready_o && !kill_i;

    assign alu_clz_en_o       = ready_o && valid_i;
    assign alu_shift_en_o     = ready_o && valid_i;
    assign alu_clz_data_rev_o = div_bitrev(w_b_abs);
    assign alu_shift_amt_o    = {1'b0, alu_clz_result_i[4:0]};
    assign div_op_b_abs_o     = w_b_abs;
    // Zero divisor is detected directly on op_b, so the CLZ "32" flag is not needed.
    assign w_unused_clz_msb   = alu_clz_result_i[5];

    assign w_div_zero = (op_b_i == '0);
    assign w_ovf      = w_signed && (op_a_i == 32'h80000000) && (op_b_i == 32'hFFFFFFFF);
    assign w_special_res = w_div_zero ? (div_is_quot(w_op) ? DIV_ZERO_QUOT : op_a_i)
                                      : (div_is_quot(w_op) ? 32'h80000000 : '0);

    assign w_diff     = {1'b0, r_rem} - {1'b0, r_div};
    assign w_rem_nxt  = w_diff[32] ? r_rem : w_diff[31:0];
    assign w_quot_nxt = {r_quot[30:0], ~w_diff[32]};
    assign w_final    = div_is_quot(r_op) ? (r_sign_q ? -w_quot_nxt : w_quot_nxt)
                                          : (r_sign_a ? -w_rem_nxt  : w_rem_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= DIV_IDLE;
            r_op     <= DIV_DIV;
            r_sign_a <= 1'b0;
            r_sign_q <= 1'b0;
            r_rem    <= '0;
            r_div    <= '0;
            r_quot   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (kill_i) begin
            r_state  <= DIV_IDLE;
            r_result <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_op;
                        r_sign_a <= w_signed & op_a_i[31];
                        r_sign_q <= w_signed & (op_a_i[31] ^ op_b_i[31]);
                        r_rem    <= w_a_abs;
                        r_div    <= alu_op_b_shifted_i;
                        r_quot   <= '0;
                        r_cnt    <= alu_clz_result_i[4:0];
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= DIV_FINISH;
                        end else begin
                            r_state  <= DIV_DIVIDE;
                        end
                    end
                end
                DIV_DIVIDE: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
                    r_div  <= r_div >> 1;
                    if (r_cnt == '0) begin
                        r_result <= w_final;
                        r_state  <= DIV_FINISH;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                DIV_FINISH: begin
                    if (ready_i) begin
                        r_state  <= DIV_IDLE;
                        r_result <= '0;
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

endmodule
